// File: rtl/stream_capture.sv
// Stream capture: takes 16-bit words from a valid/ready source and
// presents each one for two load cycles to a downstream byte writer.
module stream_capture #(
    parameter int ADDR_STEP = 2
) (
    input  logic        clk,
    input  logic        RST,
    input  logic        start,
    input  logic [15:0] baseAddr,
    input  logic [15:0] wordCount,
    input  logic [15:0] inData,
    input  logic        inValid,
    output logic        inReady,
    output logic        load,
    output logic [15:0] captured_data,
    output logic [15:0] ramBase,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        LOAD0,
        LOAD1,
        DONE
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] remaining;

    localparam logic [15:0] STEP = 16'(ADDR_STEP);

    // State register
    always_ff @(posedge clk) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a word occupies LOAD0/LOAD1, then back to WAIT
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (wordCount == 16'd0) begin
                        state_next = DONE;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (inValid) begin
                    state_next = LOAD0;
                end
            end
            LOAD0: begin
                state_next = LOAD1;
            end
            LOAD1: begin
                if (remaining == 16'd1) begin
                    state_next = DONE;
                end else begin
                    state_next = WAIT;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Address, word counter and captured word
    always_ff @(posedge clk) begin
        if (RST) begin
            ramBase       <= 16'h0000;
            remaining     <= 16'h0000;
            captured_data <= 16'h0000;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        ramBase   <= baseAddr;
                        remaining <= wordCount;
                    end
                end
                WAIT: begin
                    if (inValid) begin
                        captured_data <= inData;
                    end
                end
                LOAD1: begin
                    ramBase   <= ramBase + STEP;
                    remaining <= remaining - 16'd1;
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs registered from the next state so they align with the state
    always_ff @(posedge clk) begin
        if (RST) begin
            inReady <= 1'b0;
            load    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            inReady <= (state_next == WAIT);
            load    <= (state_next == LOAD0) || (state_next == LOAD1);
            busy    <= (state_next != IDLE);
            done    <= (state_next == DONE);
        end
    end

endmodule

// File: tb/tb_stream_capture.sv
// Bench for stream_capture: randomized transfers against an
// address/data sequence model, plus directed corner cases.
module tb_stream_capture;

    logic        clk = 1'b0;
    logic        RST;
    logic        start;
    logic [15:0] baseAddr;
    logic [15:0] wordCount;
    logic [15:0] inData;
    logic        inValid;
    logic        inReady;
    logic        load;
    logic [15:0] captured_data;
    logic [15:0] ramBase;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    stream_capture #(.ADDR_STEP(2)) dut (
        .clk(clk),
        .RST(RST),
        .start(start),
        .baseAddr(baseAddr),
        .wordCount(wordCount),
        .inData(inData),
        .inValid(inValid),
        .inReady(inReady),
        .load(load),
        .captured_data(captured_data),
        .ramBase(ramBase),
        .busy(busy),
        .done(done)
    );

    int errors = 0;
    int checks = 0;

    logic [15:0] words[$];
    logic [15:0] preset[$];
    logic [15:0] la[$];
    logic [15:0] ld[$];
    int runs[$];
    int run_len = 0;
    int done_cnt = 0;
    int busy_cnt = 0;
    int ready_cnt = 0;
    int overlap_cnt = 0;

    // Monitor: record every load cycle and count status cycles
    always @(negedge clk) begin
        if (load) begin
            la.push_back(ramBase);
            ld.push_back(captured_data);
            run_len++;
        end else if (run_len != 0) begin
            runs.push_back(run_len);
            run_len = 0;
        end
        if (done) done_cnt++;
        if (busy) busy_cnt++;
        if (inReady) ready_cnt++;
        if (load && inReady) overlap_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        la.delete();
        ld.delete();
        runs.delete();
        run_len = 0;
        done_cnt = 0;
        busy_cnt = 0;
        ready_cnt = 0;
        overlap_cnt = 0;
    endtask

    // Runs one transfer; entered and left at posedge+1
    task automatic run(input logic [15:0] base, input int cnt,
                       input int pv, input int hold_low,
                       input int restart_at);
        int idx;
        int cyc;
        bit fire;
        bit finished;
        words.delete();
        for (int i = 0; i < cnt; i++) begin
            if (i < preset.size()) words.push_back(preset[i]);
            else words.push_back(16'($urandom));
        end
        clear_mon();
        start = 1'b1;
        baseAddr = base;
        wordCount = cnt[15:0];
        @(posedge clk);
        #1;
        start = 1'b0;
        baseAddr = 16'($urandom);
        wordCount = 16'($urandom);
        idx = 0;
        cyc = 0;
        finished = 1'b0;
        while (!finished && cyc < 400) begin
            inValid = (idx < cnt) && (cyc >= hold_low) &&
                      ($urandom_range(0, 99) < pv);
            inData = (idx < cnt) ? words[idx] : 16'($urandom);
            if (cyc == restart_at) begin
                start = 1'b1;
                baseAddr = base ^ 16'h5555;
                wordCount = 16'd7;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            fire = inReady && inValid;
            if (done) finished = 1'b1;
            @(posedge clk);
            #1;
            if (fire) idx++;
            cyc++;
        end
        inValid = 1'b0;
        start = 1'b0;
        check("finished", {31'd0, finished}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Compare the recorded load cycles with the expected word sequence
    task automatic verify(input string tag, input logic [15:0] base,
                          input int cnt);
        int bad;
        logic [15:0] ea;
        check({tag, "_nload"}, 32'(la.size()), 32'(2 * cnt));
        for (int i = 0; i < cnt; i++) begin
            ea = base + 16'(2 * i);
            if (2 * i + 1 < la.size()) begin
                check({tag, "_addr"}, {la[2*i], la[2*i+1]}, {ea, ea});
                check({tag, "_data"}, {ld[2*i], ld[2*i+1]},
                      {words[i], words[i]});
            end
        end
        bad = 0;
        foreach (runs[k]) if (runs[k] != 2) bad++;
        check({tag, "_runs"}, 32'(runs.size()), 32'(cnt));
        check({tag, "_runlen"}, 32'(bad), 32'd0);
        check({tag, "_done"}, 32'(done_cnt), 32'd1);
        check({tag, "_overlap"}, 32'(overlap_cnt), 32'd0);
        check({tag, "_final"}, {16'd0, ramBase},
              {16'd0, base + 16'(2 * cnt)});
    endtask

    initial begin
        int n;
        int tries;
        logic [15:0] b;
        RST = 1'b1;
        start = 1'b0;
        baseAddr = 16'h0;
        wordCount = 16'h0;
        inData = 16'h0;
        inValid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("reset", {load, inReady, busy, done, captured_data, ramBase},
              32'd0);
        @(posedge clk);
        #1;
        RST = 1'b0;

        preset = '{16'hABCD, 16'h1234};
        run(16'h0100, 2, 100, 0, -1);
        verify("basic", 16'h0100, 2);
        preset.delete();

        run(16'h0500, 0, 100, 0, -1);
        check("zero_busy", 32'(busy_cnt), 32'd1);
        check("zero_ready", 32'(ready_cnt), 32'd0);
        check("zero_load", 32'(la.size()), 32'd0);
        check("zero_done", 32'(done_cnt), 32'd1);
        check("zero_base", {16'd0, ramBase}, 32'h0500);

        preset = '{16'h00FF};
        run(16'h0700, 1, 100, 5, -1);
        verify("hold", 16'h0700, 1);
        check("hold_ready", {31'd0, ready_cnt >= 6}, 32'd1);
        preset.delete();

        run(16'hFFFE, 2, 100, 0, -1);
        verify("wrap", 16'hFFFE, 2);

        run(16'h4000, 4, 60, 0, 3);
        verify("restart", 16'h4000, 4);

        clear_mon();
        start = 1'b1;
        baseAddr = 16'h2000;
        wordCount = 16'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        inValid = 1'b1;
        inData = 16'hBEEF;
        tries = 0;
        @(negedge clk);
        while (!load && tries < 20) begin
            tries++;
            @(negedge clk);
        end
        check("rst_reach_load", {31'd0, load}, 32'd1);
        RST = 1'b1;
        @(posedge clk);
        #1;
        RST = 1'b0;
        @(negedge clk);
        check("rst_mid", {load, inReady, busy, done, captured_data, ramBase},
              32'd0);
        check("rst_one_load", 32'(la.size()), 32'd1);
        clear_mon();
        repeat (4) @(negedge clk);
        check("rst_no_ready", 32'(ready_cnt + busy_cnt + la.size()), 32'd0);
        @(posedge clk);
        #1;
        inValid = 1'b0;
        run(16'h3000, 1, 80, 0, -1);
        verify("after_rst", 16'h3000, 1);

        for (int t = 0; t < 4; t++) begin
            b = 16'($urandom) & 16'hFFFE;
            n = $urandom_range(1, 6);
            run(b, n, $urandom_range(30, 100), 0, -1);
            verify("rand", b, n);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stream_capture.md
STREAM_CAPTURE -- requirements
Module: stream_capture

Interface
REQ-001 SHALL have parameter ADDR_STEP, default 2, giving the RAM byte-address increment per captured word (bytes written downstream per word).
REQ-002 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-003 SHALL have port RST, input, 1, synchronous active-high reset.
REQ-004 SHALL have port start, input, 1, a one-cycle request to begin a transfer; sampled only in IDLE.
REQ-005 SHALL have port baseAddr, input, 16, the first RAM byte address; sampled on accepted start.
REQ-006 SHALL have port wordCount, input, 16, the number of 16-bit words to capture; sampled on accepted start.
REQ-007 SHALL have port inData, input, 16, the upstream data word.
REQ-008 SHALL have port inValid, input, 1, qualifying inData.
REQ-009 SHALL have port inReady, output, 1, indicating the block accepts inData this cycle.
REQ-010 SHALL have port load, output, 1, the write-enable pulse to the downstream byte writer.
REQ-011 SHALL have port captured_data, output, 16, the word presented downstream; high byte is written first.
REQ-012 SHALL have port ramBase, output, 16, the RAM byte address of the high byte of captured_data.
REQ-013 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-014 SHALL have port done, output, 1, a one-cycle pulse at transfer completion.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, LOAD0, LOAD1, DONE; all outputs registered.
REQ-016 In IDLE with start=1, SHALL latch baseAddr into ramBase and wordCount into the remaining counter, then go to DONE if wordCount=0, else to WAIT.
REQ-017 start while not in IDLE SHALL be ignored.
REQ-018 inReady SHALL be 1 only in WAIT.
REQ-019 In WAIT, inValid=1 SHALL capture inData into captured_data and move to LOAD0 on the same edge; inValid=0 SHALL hold WAIT.
REQ-020 load SHALL be 1 in LOAD0 and LOAD1 only, i.e. exactly 2 consecutive cycles per word starting 1 cycle after the accepting handshake edge.
REQ-021 captured_data and ramBase SHALL remain stable throughout LOAD0 and LOAD1.
REQ-022 On leaving LOAD1, SHALL add ADDR_STEP to ramBase (modulo 2^16, wrapping 0xFFFE+2 -> 0x0000) and decrement the remaining counter.
REQ-023 From LOAD1, SHALL go to DONE if the remaining count reaches 0, else to WAIT.
REQ-024 load SHALL be 0 for at least 1 cycle (WAIT) between consecutive words, keeping the downstream high/low byte phase aligned.
REQ-025 DONE SHALL assert done for exactly 1 cycle and then go to IDLE; busy SHALL be 1 in DONE.
REQ-026 inData arriving outside WAIT SHALL not be consumed (inReady=0); upstream holds it.
REQ-027 ramBase SHALL hold its last value in IDLE after a transfer (address of the next unwritten byte).

Reset
REQ-028 RST=1 at a rising edge SHALL force IDLE, load=0, inReady=0, busy=0, done=0, captured_data=0x0000, ramBase=0x0000, and remaining count=0, overriding all other inputs.
REQ-029 RST asserted during LOAD0 SHALL drop load the following cycle, so no second-byte cycle occurs; no partial-word recovery is required.
REQ-030 After RST is released, the block SHALL require a new start before any handshake is accepted.

Verification
REQ-031 Stimulus: start, baseAddr=0x0100, wordCount=2, words 0xABCD then 0x1234 with inValid always 1. Required response: load high 2 cycles at ramBase=0x0100 with data 0xABCD, then 2 cycles at 0x0102 with 0x1234; done pulses once; final ramBase=0x0104.
REQ-032 Stimulus: start with wordCount=0. Required response: busy for 1 cycle (DONE), done pulse, load never asserted, inReady never asserted.
REQ-033 Stimulus: inValid held low 5 cycles in WAIT, then 0x00FF. Required response: inReady held high 5+ cycles, no load; a single 2-cycle load pulse with captured_data=0x00FF.
REQ-034 Stimulus: baseAddr=0xFFFE, wordCount=2. Required response: first word at ramBase=0xFFFE, second at 0x0000.
REQ-035 Stimulus: RST asserted in LOAD0 of word 1 of 3. Required response: all outputs at reset values the next cycle; a later start with wordCount=1 completes normally.
REQ-036 Stimulus: start pulsed again mid-transfer with a different baseAddr. Required response: it is ignored; addresses continue from the original base.
